// File: rtl/ahb_periph_bridge.sv
// AHB-Lite slave front end driving a simple rd_en/wr_en peripheral strobe interface.
// Handles address/data-phase pipelining, read stalls with timeout, and the two-cycle ERROR response.
module ahb_periph_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  rd_en,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  ready,
  input  logic                  error
);

  localparam int                CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRESP,
    S_READ,
    S_RDONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    accept;
  logic                    bad_xfer;
  logic                    can_accept;
  state_t                  accept_state;

  // HTRANS[0] only separates BUSY from IDLE and SEQ from NONSEQ; neither matters here.
  logic unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  assign accept   = HSEL & HREADY & HTRANS[1];
  assign bad_xfer = (HSIZE != 3'b010) | (HADDR[1:0] != 2'b00);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_comb begin
    if (bad_xfer) begin
      accept_state = S_ERR1;
    end else if (HWRITE) begin
      accept_state = S_WRITE;
    end else begin
      accept_state = S_READ;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    hrdata_d   = hrdata_q;
    cnt_d      = cnt_q;
    can_accept = 1'b0;
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;

    unique case (state_q)
      S_IDLE: begin
        can_accept = 1'b1;
      end
      S_WRITE: begin
        HREADYOUT = 1'b0;
        wr_en     = 1'b1;
        wr_data   = HWDATA;
        state_d   = S_WRESP;
      end
      S_WRESP: begin
        // The peripheral registered error on the strobe edge, so it is valid here.
        if (error) begin
          HREADYOUT = 1'b0;
          HRESP     = 1'b1;
          state_d   = S_ERR2;
        end else begin
          can_accept = 1'b1;
        end
      end
      S_READ: begin
        HREADYOUT = 1'b0;
        rd_en     = 1'b1;
        if (ready) begin
          hrdata_d = rd_data;
          state_d  = S_RDONE;
        end else begin
          if (cnt_q != TIMEOUT_C) begin
            cnt_d = cnt_inc;
          end
          if (cnt_inc == TIMEOUT_C) begin
            state_d = S_ERR1;
          end
        end
      end
      S_RDONE: begin
        can_accept = 1'b1;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        HRESP      = 1'b1;
        can_accept = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Completing states double as address phases, so back-to-back transfers need no idle gap.
    if (can_accept) begin
      state_d = S_IDLE;
      if (accept) begin
        state_d = accept_state;
        addr_d  = HADDR;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      hrdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q  <= state_d;
      addr_q   <= addr_d;
      hrdata_q <= hrdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign address = addr_q;
  assign HRDATA  = hrdata_q;

endmodule

// File: tb/tb_ahb_periph_bridge.sv
// Directed bench for ahb_periph_bridge: a scoreboard of expected strobes and responses,
// filled as transfers are issued and drained by a negedge monitor.
module tb_ahb_periph_bridge;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [DW-1:0] HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [DW-1:0] HRDATA;
  logic          rd_en;
  logic          wr_en;
  logic [AW-1:0] address;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          ready;
  logic          error;

  always #5 clk = ~clk;

  // Single-slave bus: the mux returns this slave's ready as HREADY.
  assign HREADY = HREADYOUT;

  ahb_periph_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .rd_en(rd_en), .wr_en(wr_en), .address(address), .wr_data(wr_data),
    .rd_data(rd_data), .ready(ready), .error(error)
  );

  typedef struct { logic w; logic [31:0] a; logic [31:0] d; } strobe_t;
  typedef struct { logic w; logic resp; logic [31:0] rdata; } resp_t;

  strobe_t strobe_q[$];
  resp_t   resp_q[$];
  int      total = 0;
  int      bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Peripheral model: ready after ready_delay stalled cycles; error registered on the wr_en edge.
  logic        err_mode = 1'b0;
  logic [7:0]  ready_delay = 8'd0;
  logic [7:0]  rd_cnt;
  logic [31:0] rd_val = 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= 8'd0;
      error  <= 1'b0;
    end else begin
      rd_cnt <= rd_en ? rd_cnt + 8'd1 : 8'd0;
      error  <= wr_en & err_mode;
    end
  end

  assign ready   = rd_en && (rd_cnt == ready_delay);
  assign rd_data = rd_val;

  // Data-phase tracker, advanced on the same edge the slave samples.
  logic dphase;
  always @(posedge clk or posedge rst) begin
    if (rst)                               dphase <= 1'b0;
    else if (HSEL && HREADY && HTRANS[1])  dphase <= 1'b1;
    else if (HREADY)                       dphase <= 1'b0;
  end

  int   cyc = 0;
  int   wait_cycles = 0;
  int   err1_cycles = 0;
  int   wr_cycles = 0;
  int   rd_cycles = 0;
  int   last_wr_cyc = 0;
  int   first_rd_cyc = 0;
  logic rd_en_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      cyc <= cyc + 1;
      check("strobe_excl", rd_en & wr_en, 1'b0);
      if (!wr_en) check("wr_data_idle", wr_data, 32'h0);
      if (wr_en || (rd_en && !rd_en_prev)) begin
        check("strobe_expected", strobe_q.size() != 0, 1'b1);
        if (strobe_q.size() != 0) begin
          check("strobe_dir", wr_en, strobe_q[0].w);
          check("strobe_addr", address, strobe_q[0].a);
          if (wr_en) check("strobe_wdata", wr_data, strobe_q[0].d);
          strobe_q.pop_front();
        end
      end
      if (wr_en) begin
        wr_cycles   <= wr_cycles + 1;
        last_wr_cyc <= cyc;
      end
      if (rd_en) rd_cycles <= rd_cycles + 1;
      if (rd_en && !rd_en_prev) first_rd_cyc <= cyc;
      rd_en_prev <= rd_en;
      if (dphase && !HREADYOUT) wait_cycles <= wait_cycles + 1;
      if (dphase && !HREADYOUT && HRESP) err1_cycles <= err1_cycles + 1;
      if (dphase && HREADYOUT) begin
        check("resp_expected", resp_q.size() != 0, 1'b1);
        if (resp_q.size() != 0) begin
          check("hresp", HRESP, resp_q[0].resp);
          if (!resp_q[0].w) check("hrdata", HRDATA, resp_q[0].rdata);
          resp_q.pop_front();
        end
      end
      if (!dphase) begin
        check("idle_hreadyout", HREADYOUT, 1'b1);
        check("idle_hresp", HRESP, 1'b0);
      end
    end
  end

  // Wait for a negedge with HREADYOUT high, then step past the completing edge.
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!HREADYOUT && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("wait_bound", n < 100, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic w, input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] wd, input logic exp_resp, input logic [31:0] exp_rdata);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = w;
    HADDR  = a;
    HSIZE  = sz;
    if (sz == 3'b010 && a[1:0] == 2'b00) strobe_q.push_back('{w, a, wd});
    resp_q.push_back('{w, exp_resp, exp_rdata});
    wait_ready();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWDATA = wd;
  endtask

  int w0, e0, wr0, rd0;

  task automatic snap();
    w0  = wait_cycles;
    e0  = err1_cycles;
    wr0 = wr_cycles;
    rd0 = rd_cycles;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HWDATA = '0;
    #1;
    check("rst_hreadyout", HREADYOUT, 1'b1);
    check("rst_hresp", HRESP, 1'b0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_strobes", {rd_en, wr_en}, 2'b00);
    check("rst_address", address, 32'h0);
    check("rst_wr_data", wr_data, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Plain write, no error: one wait state, one strobe.
    snap();
    addr_phase(1'b1, 32'h4000_0000, 3'b010, 32'h5, 1'b0, 32'h0);
    wait_ready();
    check("wr_waits", wait_cycles - w0, 1);
    check("wr_pulses", wr_cycles - wr0, 1);

    // Read, ready immediately.
    rd_val = 32'hA; ready_delay = 8'd0;
    snap();
    addr_phase(1'b0, 32'h4000_0008, 3'b010, 32'h0, 1'b0, 32'hA);
    wait_ready();
    check("rd0_waits", wait_cycles - w0, 1);
    check("rd0_cycles", rd_cycles - rd0, 1);

    // Read stalled three cycles.
    rd_val = 32'h1234; ready_delay = 8'd3;
    snap();
    addr_phase(1'b0, 32'h4000_000C, 3'b010, 32'h0, 1'b0, 32'h1234);
    wait_ready();
    check("rd3_waits", wait_cycles - w0, 4);
    check("rd3_cycles", rd_cycles - rd0, 4);

    // Read timeout: TO READ cycles, then two-cycle ERROR; HRDATA keeps old value.
    rd_val = 32'hBEEF; ready_delay = 8'd255;
    snap();
    addr_phase(1'b0, 32'h4000_0010, 3'b010, 32'h0, 1'b1, 32'h1234);
    wait_ready();
    check("to_cycles", rd_cycles - rd0, TO);
    check("to_waits", wait_cycles - w0, TO + 1);
    check("to_err1", err1_cycles - e0, 1);

    // Write with peripheral error.
    err_mode = 1'b1;
    snap();
    addr_phase(1'b1, 32'h4000_0020, 3'b010, 32'hDEAD, 1'b1, 32'h0);
    wait_ready();
    err_mode = 1'b0;
    check("werr_pulses", wr_cycles - wr0, 1);
    check("werr_waits", wait_cycles - w0, 2);
    check("werr_err1", err1_cycles - e0, 1);

    // Unsupported size and misalignment: no strobe, two-cycle ERROR.
    snap();
    addr_phase(1'b1, 32'h4000_0000, 3'b001, 32'h99, 1'b1, 32'h0);
    wait_ready();
    addr_phase(1'b0, 32'h4000_0002, 3'b010, 32'h0, 1'b1, 32'h1234);
    wait_ready();
    check("bad_wr_pulses", wr_cycles - wr0, 0);
    check("bad_rd_cycles", rd_cycles - rd0, 0);
    check("bad_waits", wait_cycles - w0, 2);
    check("bad_err1", err1_cycles - e0, 2);

    // Back-to-back write then read, read accepted during WRESP.
    rd_val = 32'h77; ready_delay = 8'd0;
    addr_phase(1'b1, 32'h4000_0004, 3'b010, 32'h77, 1'b0, 32'h0);
    addr_phase(1'b0, 32'h4000_0004, 3'b010, 32'h0, 1'b0, 32'h77);
    wait_ready();
    check("b2b_gap", first_rd_cyc - last_wr_cyc, 2);

    // IDLE, BUSY and deselected NONSEQ: no action.
    snap();
    HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 32'h4000_0050;
    repeat (2) @(posedge clk);
    HTRANS = 2'b01;
    repeat (2) @(posedge clk);
    HSEL = 1'b0; HTRANS = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    HTRANS = 2'b00;
    check("noop_waits", wait_cycles - w0, 0);
    check("noop_strobes", (wr_cycles - wr0) + (rd_cycles - rd0), 0);
    check("noop_address", address, 32'h4000_0004);

    // Reset during a stalled read.
    ready_delay = 8'd255;
    addr_phase(1'b0, 32'h4000_0040, 3'b010, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    check("pre_rst_rd_en", rd_en, 1'b1);
    rst = 1'b1;
    #1;
    check("arst_rd_en", rd_en, 1'b0);
    check("arst_hreadyout", HREADYOUT, 1'b1);
    check("arst_hresp", HRESP, 1'b0);
    check("arst_hrdata", HRDATA, 32'h0);
    check("arst_address", address, 32'h0);
    strobe_q.delete();
    resp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    snap();
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_strobes", (wr_cycles - wr0) + (rd_cycles - rd0), 0);

    // Normal read after reset, one stall cycle.
    rd_val = 32'h55; ready_delay = 8'd1;
    snap();
    addr_phase(1'b0, 32'h4000_0030, 3'b010, 32'h0, 1'b0, 32'h55);
    wait_ready();
    check("post_rst_waits", wait_cycles - w0, 2);
    check("post_rst_hrdata", HRDATA, 32'h55);

    repeat (2) @(posedge clk);
    check("strobe_q_empty", strobe_q.size(), 0);
    check("resp_q_empty", resp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
